// File: rtl/pipes_list_pkg.sv
// Shared types for the pipe list: the pipe record, its flat width and the
// pass-control state encoding.
package pipes_list_pkg;

    // One pipe: horizontal position and gap position.
    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
    } pipe_t;

    // Storage and ports only ever see the record as a flat vector.
    localparam int PIPE_W = $bits(pipe_t);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } state_t;

endpackage : pipes_list_pkg

// File: rtl/pipes_list.sv
// Compact list of active pipes (index 0 = oldest). Appends via insert strobe;
// an update pass visits every entry once, writing back or dropping it, and
// compacts the kept entries in place.
module pipes_list
    import pipes_list_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              insert_en,
    input  logic [PIPE_W-1:0] insert_data,
    input  logic              iter_start,
    output logic              iter_done,
    input  logic [PIPE_W-1:0] iter_in,
    output logic [PIPE_W-1:0] iter_out,
    input  logic              iter_remove
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_rd;
    logic [CW-1:0]     r_wr;
    logic [PIPE_W-1:0] r_mem [DEPTH];

    logic w_do_insert;
    logic w_do_start;
    logic w_do_step;
    logic w_last;
    logic w_keep;

    // Next-state and per-edge action decode; start beats insert, empty list never enters a pass.
    always_comb begin
        w_state_nxt = r_state;
        w_do_insert = 1'b0;
        w_do_start  = 1'b0;
        w_do_step   = 1'b0;
        w_last      = (r_rd == (r_count - ONE_C));
        w_keep      = ~iter_remove;
        case (r_state)
            ST_IDLE: begin
                if (iter_start) begin
                    if (r_count != ZERO_C) begin
                        w_do_start  = 1'b1;
                        w_state_nxt = ST_ITER;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (insert_en && (r_count < DEPTH_C)) begin
                    w_do_insert = 1'b1;
                end else begin
                    w_do_insert = 1'b0;
                end
            end
            ST_ITER: begin
                w_do_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ITER;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; a low clock enable freezes the pass wherever it is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (ce) begin
            r_state <= w_state_nxt;
        end
    end

    // Count and read/write indices; the final step of a pass commits the kept total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= ZERO_C;
            r_rd    <= ZERO_C;
            r_wr    <= ZERO_C;
        end else if (ce) begin
            if (w_do_insert) begin
                r_count <= r_count + ONE_C;
            end else if (w_do_start) begin
                r_rd <= ZERO_C;
                r_wr <= ZERO_C;
            end else if (w_do_step) begin
                r_rd <= r_rd + ONE_C;
                if (w_keep) begin
                    r_wr <= r_wr + ONE_C;
                end
                if (w_last) begin
                    r_count <= r_wr + (w_keep ? ONE_C : ZERO_C);
                end
            end
        end
    end

    // Record storage: append at the tail, or compact write-back during a pass.
    always_ff @(posedge clk) begin
        if (ce && w_do_insert) begin
            r_mem[r_count[IW-1:0]] <= insert_data;
        end else if (ce && w_do_step && w_keep) begin
            r_mem[r_wr[IW-1:0]] <= iter_in;
        end
    end

    assign iter_done = (r_state == ST_IDLE);
    assign iter_out  = (r_state == ST_ITER) ? r_mem[r_rd[IW-1:0]] : {PIPE_W{1'b0}};

endmodule : pipes_list

// File: tb/tb_pipes_list.sv
// Directed bench for pipes_list with a list model and an expected-output queue.
module tb_pipes_list;
    import pipes_list_pkg::*;

    localparam int DEPTH = 8;
    localparam int W     = PIPE_W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ce  = 1'b1;
    logic         insert_en = 1'b0;
    logic [W-1:0] insert_data = '0;
    logic         iter_start = 1'b0;
    logic         iter_done;
    logic [W-1:0] iter_in = '0;
    logic [W-1:0] iter_out;
    logic         iter_remove = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] model[$];
    logic [W-1:0] sb[$];

    pipes_list #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .insert_en(insert_en), .insert_data(insert_data),
        .iter_start(iter_start), .iter_done(iter_done),
        .iter_in(iter_in), .iter_out(iter_out), .iter_remove(iter_remove)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_insert(input logic [W-1:0] v);
        @(negedge clk);
        insert_en   = 1'b1;
        insert_data = v;
        if (model.size() < DEPTH) model.push_back(v);
    endtask

    task automatic end_insert();
        @(negedge clk);
        insert_en = 1'b0;
    endtask

    // mode 0: pass-through, 1: +1, 2: remove first entry.
    task automatic run_pass(input int mode, input int hold_at, input bit ins_during,
                            input bit ins_with_start);
        int n;
        int cyc;
        logic [W-1:0] exp;
        logic [W-1:0] nm[$];
        n = model.size();
        foreach (model[i]) sb.push_back(model[i]);
        @(negedge clk);
        iter_start = 1'b1;
        if (ins_with_start) begin
            insert_en   = 1'b1;
            insert_data = 21'h0ABCD;
        end
        @(negedge clk);
        iter_start = 1'b0;
        insert_en  = 1'b0;
        if (n == 0) begin
            chk("empty_done", {31'd0, iter_done}, 32'd1);
            chk("empty_out", 32'(iter_out), 32'd0);
        end
        cyc = 0;
        while (iter_done === 1'b0 && cyc < DEPTH + 4) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(cyc), 32'(n));
                exp = '0;
            end else begin
                exp = sb.pop_front();
            end
            chk("iter_out", 32'(iter_out), 32'(exp));
            if (cyc == hold_at) begin
                ce          = 1'b0;
                iter_remove = 1'b1;
                iter_in     = 21'h1FFFFF;
                insert_en   = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("hold_out", 32'(iter_out), 32'(exp));
                    chk("hold_done", {31'd0, iter_done}, 32'd0);
                end
                ce        = 1'b1;
                insert_en = 1'b0;
            end
            if (ins_during) begin
                insert_en   = 1'b1;
                insert_data = 21'h01234;
            end
            iter_remove = 1'b0;
            case (mode)
                1:       iter_in = exp + 21'd1;
                2:       begin iter_in = exp; iter_remove = (cyc == 0); end
                default: iter_in = exp;
            endcase
            if (!iter_remove) nm.push_back(iter_in);
            @(negedge clk);
            cyc++;
        end
        insert_en   = 1'b0;
        iter_remove = 1'b0;
        chk("pass_cycles", 32'(cyc), 32'(n));
        chk("pass_done", {31'd0, iter_done}, 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
        model = nm;
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_done", {31'd0, iter_done}, 32'd1);
        chk("rst_out", 32'(iter_out), 32'd0);
        rst = 1'b0;

        // Fill 1..4 and pass-through five times.
        for (int i = 1; i <= 4; i++) do_insert(W'(i));
        end_insert();
        for (int p = 0; p < 5; p++) run_pass(0, -1, 1'b0, 1'b0);

        // Increment four times, then confirm 5..8.
        for (int p = 0; p < 4; p++) run_pass(1, -1, 1'b0, 1'b0);
        run_pass(0, -1, 1'b0, 1'b0);

        // Drop the head each pass until empty, then pass on empty list.
        for (int p = 0; p < 4; p++) run_pass(2, -1, 1'b0, 1'b0);
        chk("model_empty", 32'(model.size()), 32'd0);
        run_pass(0, -1, 1'b0, 1'b0);

        // Overfill: last insert dropped.
        for (int i = 0; i <= DEPTH; i++) do_insert(W'(16 + i));
        end_insert();
        run_pass(0, -1, 1'b0, 1'b0);

        // Make room, then insert during a pass and with a start pulse: both dropped.
        run_pass(2, -1, 1'b0, 1'b0);
        run_pass(0, -1, 1'b1, 1'b0);
        run_pass(0, -1, 1'b0, 1'b1);

        // Clock-enable freeze mid-pass.
        run_pass(1, 2, 1'b0, 1'b0);
        run_pass(0, -1, 1'b0, 1'b0);

        // Reset mid-pass empties the list.
        @(negedge clk);
        iter_start = 1'b1;
        @(negedge clk);
        iter_start = 1'b0;
        chk("mid_busy", {31'd0, iter_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_done", {31'd0, iter_done}, 32'd1);
        chk("mid_rst_out", 32'(iter_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model.delete();
        run_pass(0, -1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipes_list
